spi_slave_rx: RTL and testbench
===============================

Name: spi_slave_rx

Overview:
- Parametrised SPI slave receiver; successor to the raw SCK-clocked byte shifter.
- Runs entirely in the system clock domain. SCK, CS_N and MOSI are oversampled through synchronisers.
- Supports all four SPI modes, any word width and MSB- or LSB-first order.
- Delivers each received word through a valid/ready handshake, with overrun detection and a per-frame word count. Feeds the column/command buffer logic downstream.

Parameters:
- DATA_W, 8: bits per word (2..32).
- MSB_FIRST, 1: 1 = first bit received is bit DATA_W-1; 0 = first bit is bit 0.
- CPOL, 0: SCK idle level.
- CPHA, 0: 0 = sample on leading edge; 1 = sample on trailing edge.
- SYNC_STAGES, 2: synchroniser depth on SCK, CS_N and MOSI (2..3).
- CNT_W, 8: width of word_count.

Ports:
- clk, input, 1: system clock.
- rst_n, input, 1: reset.
- CS_N, input, 1: chip select, active-low, asynchronous to clk.
- SCK, input, 1: SPI clock, asynchronous to clk; f_SCK ≤ f_clk/4.
- MOSI, input, 1: serial data.
- rx_data, output, DATA_W: last completed word.
- rx_valid, output, 1: rx_data holds an unaccepted word.
- rx_ready, input, 1: consumer accepts the word when rx_valid && rx_ready.
- frame_active, output, 1: synchronised CS_N is low.
- word_count, output, CNT_W: words completed in the current frame, saturating.
- overrun, output, 1: sticky flag; a word completed while the previous word was not accepted.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low.
- Reset values while rst_n is low: rx_data=0, rx_valid=0, frame_active=0, word_count=0, overrun=0, bit counter=0, shift register=0, FSM=IDLE. Synchroniser flops reset to their idle levels: SCK=CPOL, CS_N=1, MOSI=0.
- Synchronisation: each input passes through SYNC_STAGES flops. One extra SCK flop provides edge detection.
- Edge definitions:
  - Leading edge = rising when CPOL=0, falling when CPOL=1.
  - Sample edge = leading edge when CPHA=0, trailing edge when CPHA=1.
- FSM IDLE:
  - Ignore SCK.
  - On synced CS_N going 1→0: go to ACTIVE, set frame_active=1, word_count=0, overrun=0, bit counter=0.
- FSM ACTIVE:
  - On each detected sample edge, shift the synced MOSI into the shift register: from the LSB side if MSB_FIRST=1, from the MSB side if MSB_FIRST=0. Increment the bit counter.
  - When the DATA_W-th bit is sampled, the word is complete. In the next clk cycle, load the completed word into rx_data, set rx_valid=1, increment word_count (saturating at 2^CNT_W-1), and reset the bit counter to 0.
  - Latency: rx_valid rises 1 clk after the cycle in which the final sample edge is detected. Detection occurs SYNC_STAGES+1 clk cycles after the pin transition, with ±1 cycle of asynchronous uncertainty.
- CS_N deasserted mid-word (synced 0→1):
  - Return to IDLE and set frame_active=0.
  - Discard the partial word: no rx_valid and no word_count change.
  - rx_data, rx_valid, word_count and overrun keep their values until the next frame start. word_count and overrun are cleared only at that frame start; the held word is still handshaken normally.
- Handshake:
  - rx_valid stays high until a cycle with rx_valid && rx_ready; it then drops the following cycle.
  - rx_data is stable while rx_valid=1, except on an accept cycle that coincides with a new completion.
- Completion and acceptance in the same cycle: load the new word and keep rx_valid=1. overrun is not set.
- Completion while rx_valid=1 and rx_ready=0: drop the new word, keep the held word, set overrun=1. word_count still increments.
- SCK edges while CS_N is high are ignored. A CPHA=1 leading edge shifts nothing.
- word_count saturates and does not wrap.

Test Plan:
- Mode 0, DATA_W=8, MSB_FIRST=1, f_SCK=f_clk/8, send 0xA5 with rx_ready=1 → one rx_valid pulse, rx_data=0xA5, word_count=1, overrun=0.
- All four CPOL/CPHA builds, send 0x3C then 0xC3 in one frame → rx_data sequence 0x3C, 0xC3; word_count=2 in every mode.
- MSB_FIRST=0, DATA_W=16, send bit stream for 0x1234 LSB-first → rx_data=0x1234.
- rx_ready=0, send 0x11 then 0x22 → rx_data stays 0x11, overrun=1, word_count=2. Raise rx_ready → rx_valid drops next cycle.
- Raise CS_N after 5 bits of 0xFF → no rx_valid, word_count unchanged, frame_active=0. Next frame sends 0x81 → rx_data=0x81, word_count=1.
- Assert rst_n=0 mid-word with rx_valid=1 → all outputs 0 immediately (asynchronously). After release, a full byte 0x5A is received correctly.

Source files
------------

// File: rtl/spi_slave_rx.sv
// spi_slave_rx
// SPI slave receiver that runs entirely in the system clock domain.
// SCK, CS_N and MOSI are oversampled through synchronisers. Each
// received word is offered on a valid/ready handshake. The block also
// keeps a per-frame word count and a sticky overrun flag.
//
// Ports:
//   clk          system clock
//   rst_n        asynchronous active-low reset
//   CS_N         chip select, active-low, asynchronous to clk
//   SCK          SPI clock, asynchronous to clk (f_SCK <= f_clk/4)
//   MOSI         serial data in
//   rx_data      last completed word
//   rx_valid     rx_data holds a word that has not been accepted
//   rx_ready     consumer accepts the word when rx_valid && rx_ready
//   frame_active synchronised CS_N is low
//   word_count   words completed in the current frame (saturating)
//   overrun      sticky: a word completed while the previous one was pending
module spi_slave_rx #(
  parameter int DATA_W      = 8,
  parameter int MSB_FIRST   = 1,
  parameter int CPOL        = 0,
  parameter int CPHA        = 0,
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              CS_N,
  input  logic              SCK,
  input  logic              MOSI,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  input  logic              rx_ready,
  output logic              frame_active,
  output logic [CNT_W-1:0]  word_count,
  output logic              overrun
);

  localparam logic                 SCK_IDLE = (CPOL != 0);
  localparam int                   BIT_W    = $clog2(DATA_W);
  localparam logic [BIT_W-1:0]     LAST_BIT = BIT_W'(DATA_W - 1);

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t state_reg, state_next;

  logic [SYNC_STAGES-1:0] sck_sync, cs_sync, mosi_sync;
  logic                   sck_prev;
  logic                   sck_s, cs_s, mosi_s;
  logic                   sck_rise, sck_fall, lead_edge, trail_edge, sample_edge;
  logic                   frame_start, shift_en;
  logic [BIT_W-1:0]       bit_cnt;
  logic [DATA_W-1:0]      shift;
  logic                   word_done;

  // Synchronisers plus one extra SCK flop for edge detection. They
  // reset to the idle levels of the bus so that no edge is seen when
  // reset is released.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sck_sync  <= {SYNC_STAGES{SCK_IDLE}};
      cs_sync   <= '1;
      mosi_sync <= '0;
      sck_prev  <= SCK_IDLE;
    end else begin
      sck_sync  <= {sck_sync[SYNC_STAGES-2:0], SCK};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], CS_N};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], MOSI};
      sck_prev  <= sck_s;
    end
  end

  assign sck_s  = sck_sync[SYNC_STAGES-1];
  assign cs_s   = cs_sync[SYNC_STAGES-1];
  assign mosi_s = mosi_sync[SYNC_STAGES-1];

  assign sck_rise    = sck_s & ~sck_prev;
  assign sck_fall    = ~sck_s & sck_prev;
  assign lead_edge   = SCK_IDLE ? sck_fall : sck_rise;
  assign trail_edge  = SCK_IDLE ? sck_rise : sck_fall;
  assign sample_edge = (CPHA != 0) ? trail_edge : lead_edge;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // IDLE is only left again after synced CS_N has been seen high, so a
  // low CS_N while in IDLE always means a fresh 1->0 transition.
  always_comb begin
    state_next  = state_reg;
    frame_start = 1'b0;
    case (state_reg)
      IDLE: begin
        if (!cs_s) begin
          state_next  = ACTIVE;
          frame_start = 1'b1;
        end
      end
      ACTIVE: begin
        if (cs_s) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign frame_active = (state_reg == ACTIVE);
  assign shift_en     = (state_reg == ACTIVE) && !cs_s && sample_edge;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt    <= '0;
      shift      <= '0;
      word_done  <= 1'b0;
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      word_count <= '0;
      overrun    <= 1'b0;
    end else begin
      word_done <= 1'b0;

      if (shift_en) begin
        if (MSB_FIRST != 0) begin
          shift <= {shift[DATA_W-2:0], mosi_s};
        end else begin
          shift <= {mosi_s, shift[DATA_W-1:1]};
        end
        bit_cnt <= bit_cnt + 1'b1;
        if (bit_cnt == LAST_BIT) begin
          word_done <= 1'b1;
        end
      end

      // The completed word sits in shift during the cycle after the last
      // sample. A completed word is delivered even if CS_N rose meanwhile.
      if (word_done) begin
        bit_cnt <= '0;
        if (word_count != '1) begin
          word_count <= word_count + 1'b1;
        end
        if (!rx_valid || rx_ready) begin
          rx_data  <= shift;
          rx_valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end

      if (frame_start) begin
        bit_cnt    <= '0;
        word_count <= '0;
        overrun    <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_spi_slave_rx.sv
// tb_spi_slave_rx
// Drives one SPI bus into four 8-bit receivers (one per CPOL/CPHA mode)
// and a 16-bit LSB-first receiver. Received words are captured at the
// handshake and compared against the words the bench sent.
module tb_spi_slave_rx;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, cs_n, mosi, ph0, ph1, rand_rdy;
  logic [3:0] sck_l, rdy, rdy_man, rdy_rnd;
  logic [7:0] rxd [4];
  logic [7:0] wc [4];
  logic [3:0] rxv, fa, ov;
  logic [15:0] rxd16;
  logic        rxv16, fa16, ov16, rdy16;
  logic [2:0]  wc16;

  int checks = 0;
  int errors = 0;

  logic [7:0]  cap_mem [4][256];
  int          cap_n [4] = '{0, 0, 0, 0};
  int          base [4];
  logic [15:0] cap16 [64];
  int          cap16_n = 0;

  assign rdy = rand_rdy ? rdy_rnd : rdy_man;

  // ph0 is the "active" phase seen by CPHA=0 slaves, ph1 by CPHA=1 slaves.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_mode
      localparam int CP = gi / 2;
      localparam int CH = gi % 2;
      assign sck_l[gi] = (CP != 0) ^ ((CH != 0) ? ph1 : ph0);
      spi_slave_rx #(
        .DATA_W(8), .MSB_FIRST(1), .CPOL(CP), .CPHA(CH),
        .SYNC_STAGES((gi == 3) ? 3 : 2), .CNT_W(8)
      ) u_dut (
        .clk(clk), .rst_n(rst_n), .CS_N(cs_n), .SCK(sck_l[gi]), .MOSI(mosi),
        .rx_data(rxd[gi]), .rx_valid(rxv[gi]), .rx_ready(rdy[gi]),
        .frame_active(fa[gi]), .word_count(wc[gi]), .overrun(ov[gi])
      );
    end
  endgenerate

  spi_slave_rx #(
    .DATA_W(16), .MSB_FIRST(0), .CPOL(0), .CPHA(0), .SYNC_STAGES(2), .CNT_W(3)
  ) u_dut16 (
    .clk(clk), .rst_n(rst_n), .CS_N(cs_n), .SCK(sck_l[0]), .MOSI(mosi),
    .rx_data(rxd16), .rx_valid(rxv16), .rx_ready(rdy16),
    .frame_active(fa16), .word_count(wc16), .overrun(ov16)
  );

  // Handshake monitor: a word is consumed at the posedge following a
  // negedge where valid && ready are both high.
  always @(negedge clk) begin
    for (int m = 0; m < 4; m++) begin
      if (rxv[m] && rdy[m] && cap_n[m] < 256) begin
        cap_mem[m][cap_n[m]] <= rxd[m];
        cap_n[m] <= cap_n[m] + 1;
      end
    end
    if (rxv16 && rdy16 && cap16_n < 64) begin
      cap16[cap16_n] <= rxd16;
      cap16_n <= cap16_n + 1;
    end
  end

  // About 75% ready per cycle when random ready is selected.
  initial begin
    rdy_rnd = 4'hF;
    forever begin
      @(posedge clk);
      #1;
      rdy_rnd = 4'($urandom) | 4'($urandom);
    end
  end

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // One bit per 8 clk: MOSI changes at t0, CPHA=1 leading edge at t0,
  // CPHA=0 leading edge at t0+2, CPHA=1 trailing at t0+4, CPHA=0 trailing at t0+6.
  task automatic send_bits(input logic [31:0] w, input int n, input bit msb);
    for (int i = 0; i < n; i++) begin
      mosi = msb ? w[n-1-i] : w[i];
      ph1 = 1'b1;
      wait_clk(2);
      ph0 = 1'b1;
      wait_clk(2);
      ph1 = 1'b0;
      wait_clk(2);
      ph0 = 1'b0;
      wait_clk(2);
    end
  endtask

  task automatic frame_begin();
    for (int m = 0; m < 4; m++) base[m] = cap_n[m];
    cs_n = 1'b0;
    wait_clk(6);
  endtask

  task automatic frame_end();
    wait_clk(6);
    cs_n = 1'b1;
    wait_clk(8);
  endtask

  task automatic drain();
    int k;
    k = 0;
    while (rxv != 4'h0 && k < 60) begin
      wait_clk(1);
      k++;
    end
    check("drain rx_valid", {28'h0, rxv}, 32'h0);
  endtask

  task automatic check_frame(input string tag, input logic [7:0] exp_w [8],
                             input int n, input int exp_cnt);
    for (int m = 0; m < 4; m++) begin
      check($sformatf("%s m%0d words", tag, m), cap_n[m] - base[m], n);
      for (int w = 0; w < n; w++) begin
        if (base[m] + w < cap_n[m])
          check($sformatf("%s m%0d word%0d", tag, m, w), {24'h0, cap_mem[m][base[m]+w]}, {24'h0, exp_w[w]});
      end
      check($sformatf("%s m%0d word_count", tag, m), {24'h0, wc[m]}, exp_cnt);
      check($sformatf("%s m%0d overrun", tag, m), {31'h0, ov[m]}, 32'h0);
      check($sformatf("%s m%0d frame_active", tag, m), {31'h0, fa[m]}, 32'h0);
    end
  endtask

  typedef struct {
    logic [7:0] b0;
    logic [7:0] b1;
    int         nw;
    int         tail;
    int         exp_cnt;
  } vec_t;

  vec_t       tbl [6];
  logic [7:0] exp_w [8];

  initial begin
    tbl[0] = '{8'hA5, 8'h00, 1, 0, 1};
    tbl[1] = '{8'h3C, 8'hC3, 2, 0, 2};
    tbl[2] = '{8'hFF, 8'h00, 0, 5, 0};
    tbl[3] = '{8'h81, 8'h00, 1, 0, 1};
    tbl[4] = '{8'h12, 8'h34, 2, 5, 2};
    tbl[5] = '{8'h00, 8'hFF, 2, 3, 2};

    rst_n = 1'b0; cs_n = 1'b1; mosi = 1'b0; ph0 = 1'b0; ph1 = 1'b0;
    rdy_man = 4'hF; rdy16 = 1'b1; rand_rdy = 1'b0;
    #3;
    for (int m = 0; m < 4; m++) begin
      check($sformatf("reset m%0d rx_data", m), {24'h0, rxd[m]}, 32'h0);
      check($sformatf("reset m%0d rx_valid", m), {31'h0, rxv[m]}, 32'h0);
      check($sformatf("reset m%0d flags", m), {24'h0, wc[m]} | {31'h0, fa[m]} | {31'h0, ov[m]}, 32'h0);
    end
    check("reset rx_data16", {16'h0, rxd16}, 32'h0);
    wait_clk(3);
    rst_n = 1'b1;
    wait_clk(5);

    // Table of frames applied to all four modes.
    for (int t = 0; t < 6; t++) begin
      frame_begin();
      check($sformatf("vec%0d frame_active", t), {28'h0, fa}, 32'hF);
      if (tbl[t].nw >= 1) send_bits({24'h0, tbl[t].b0}, 8, 1'b1);
      if (tbl[t].nw >= 2) send_bits({24'h0, tbl[t].b1}, 8, 1'b1);
      if (tbl[t].tail > 0) send_bits(32'hFFFF_FFFF, tbl[t].tail, 1'b1);
      frame_end();
      drain();
      exp_w = '{tbl[t].b0, tbl[t].b1, 8'h0, 8'h0, 8'h0, 8'h0, 8'h0, 8'h0};
      check_frame($sformatf("vec%0d", t), exp_w, tbl[t].nw, tbl[t].exp_cnt);
      $display("vec %0d: sent %0d words + %0d bits", t, tbl[t].nw, tbl[t].tail);
    end

    // Overrun on mode 0: second word arrives while the first is held.
    rdy_man[0] = 1'b0;
    frame_begin();
    send_bits(32'h11, 8, 1'b1);
    send_bits(32'h22, 8, 1'b1);
    frame_end();
    check("ovr rx_data", {24'h0, rxd[0]}, 32'h11);
    check("ovr rx_valid", {31'h0, rxv[0]}, 32'h1);
    check("ovr overrun", {31'h0, ov[0]}, 32'h1);
    check("ovr word_count", {24'h0, wc[0]}, 32'h2);
    rdy_man[0] = 1'b1;
    wait_clk(1);
    check("ovr rx_valid drop", {31'h0, rxv[0]}, 32'h0);
    check("ovr captured", {24'h0, cap_mem[0][base[0]]}, 32'h11);
    check("ovr capture count", cap_n[0] - base[0], 32'h1);
    $display("overrun: held 0x%0h", rxd[0]);

    // 16-bit LSB-first receiver.
    begin
      int b16;
      b16 = cap16_n;
      frame_begin();
      send_bits(32'h1234, 16, 1'b0);
      frame_end();
      check("lsb16 rx_data", {16'h0, rxd16}, 32'h1234);
      check("lsb16 word_count", {29'h0, wc16}, 32'h1);
      check("lsb16 captured", cap16_n - b16, 32'h1);
      $display("lsb16: rx_data 0x%0h", rxd16);

      b16 = cap16_n;
      frame_begin();
      for (int i = 0; i < 9; i++) send_bits(32'h1111 * (i + 1), 16, 1'b0);
      frame_end();
      wait_clk(4);
      check("sat16 word_count", {29'h0, wc16}, 32'h7);
      check("sat16 captured", cap16_n - b16, 32'h9);
      if (cap16_n > 0) check("sat16 last word", {16'h0, cap16[cap16_n-1]}, 32'h9999);
      check("sat16 overrun", {31'h0, ov16}, 32'h0);
      check("sat16 frame_active", {31'h0, fa16}, 32'h0);
      $display("sat16: word_count %0d", wc16);
    end

    // Asynchronous reset mid-word while a word is held.
    rdy_man[0] = 1'b0;
    frame_begin();
    send_bits(32'h77, 8, 1'b1);
    send_bits(32'h5, 3, 1'b1);
    check("rst pre rx_valid", {31'h0, rxv[0]}, 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst rx_data", {24'h0, rxd[0]}, 32'h0);
    check("rst rx_valid", {31'h0, rxv[0]}, 32'h0);
    check("rst frame_active", {31'h0, fa[0]}, 32'h0);
    check("rst word_count", {24'h0, wc[0]}, 32'h0);
    check("rst overrun", {31'h0, ov[0]}, 32'h0);
    cs_n = 1'b1; ph0 = 1'b0; ph1 = 1'b0;
    wait_clk(3);
    rst_n = 1'b1;
    rdy_man[0] = 1'b1;
    wait_clk(4);
    frame_begin();
    send_bits(32'h5A, 8, 1'b1);
    frame_end();
    drain();
    exp_w = '{8'h5A, 8'h0, 8'h0, 8'h0, 8'h0, 8'h0, 8'h0, 8'h0};
    check_frame("post-rst", exp_w, 1, 1);
    $display("post-reset: rx_data 0x%0h", rxd[0]);

    // Random frames with random consumer readiness.
    rand_rdy = 1'b1;
    for (int f = 0; f < 15; f++) begin
      int nb;
      nb = $urandom_range(1, 4);
      for (int i = 0; i < 8; i++) exp_w[i] = (i < nb) ? 8'($urandom) : 8'h0;
      frame_begin();
      for (int i = 0; i < nb; i++) send_bits({24'h0, exp_w[i]}, 8, 1'b1);
      frame_end();
      drain();
      check_frame($sformatf("rnd%0d", f), exp_w, nb, (nb > 255) ? 255 : nb);
      $display("rnd %0d: %0d words", f, nb);
    end
    rand_rdy = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
